// File: rtl/xillybus_lite_regs.sv
// Xillybus-Lite responder: register bank, timer/compare, doorbell FIFO, IRQ.
// Define XLITE_REGS_TIMER_EN to build the CNT/CMP timer; otherwise they read 0.
module xillybus_lite_regs #(
  parameter logic [31:0] ID_VALUE = 32'h584C_0001,
  parameter int          FIFO_AW  = 4
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        user_wren,
  input  logic [3:0]  user_wstrb,
  input  logic        user_rden,
  input  logic [31:0] user_addr,
  input  logic [31:0] user_wr_data,
  output logic [31:0] user_rd_data,
  output logic        user_irq
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};

  logic [2:0]         ofs;
  logic [4:0]         ctrl;
  logic [1:0]         irq_stat;
  logic [31:0]        scratch;
  logic [31:0]        cnt_q;
  logic [31:0]        cmp_q;
  logic [31:0]        rd_mux;
  logic [31:0]        status;
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   level;
  logic               empty;
  logic               full;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               ovf_set;
  logic               hit_set;
  logic [1:0]         clr;
  logic               unused_addr;

  assign ofs         = user_addr[4:2];
  assign unused_addr = ^{user_addr[31:5], user_addr[1:0]};

  function automatic logic [31:0] bmerge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    bmerge = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) bmerge[8*i +: 8] = d[8*i +: 8];
  endfunction

  assign empty    = (level == '0);
  assign full     = (level == FULL_LVL);
  assign push_req = user_wren && ofs == 3'd7 && |user_wstrb;
  assign pop      = user_rden && ofs == 3'd7 && !empty;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign clr      = (user_wren && ofs == 3'd3 && user_wstrb[0])
                  ? user_wr_data[1:0] : 2'b00;

`ifdef XLITE_REGS_TIMER_EN
  logic hit;
  logic wr_cnt;
  logic wr_cmp;

  assign hit     = ctrl[0] && cnt_q == cmp_q;
  assign hit_set = hit;
  assign wr_cnt  = user_wren && ofs == 3'd4;
  assign wr_cmp  = user_wren && ofs == 3'd5;

  // free-running counter; a bus write beats both increment and reload
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      cnt_q <= '0;
      cmp_q <= '0;
    end else begin
      if (wr_cnt)
        cnt_q <= bmerge(cnt_q, user_wr_data, user_wstrb);
      else if (ctrl[0])
        cnt_q <= (ctrl[4] && hit) ? '0 : cnt_q + 32'd1;
      if (wr_cmp)
        cmp_q <= bmerge(cmp_q, user_wr_data, user_wstrb);
    end
  end
`else
  assign cnt_q   = '0;
  assign cmp_q   = '0;
  assign hit_set = 1'b0;
`endif

  // control and scratch registers with byte strobes
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      ctrl    <= '0;
      scratch <= '0;
    end else begin
      if (user_wren && ofs == 3'd1 && user_wstrb[0])
        ctrl <= user_wr_data[4:0];
      if (user_wren && ofs == 3'd6)
        scratch <= bmerge(scratch, user_wr_data, user_wstrb);
    end
  end

  // sticky status; a set in the same cycle as its clear wins
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) irq_stat <= '0;
    else irq_stat <= (irq_stat & ~clr) | {ovf_set, hit_set};
  end

  // fifo pointers and fill level
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // fifo storage, no reset needed since level gates every read
  always_ff @(posedge bus_clk) begin
    if (push) mem[wptr] <= user_wr_data;
  end

  // status word assembly
  always_comb begin
    status = '0;
    status[0] = empty;
    status[1] = full;
    status[FIFO_AW+8:8] = level;
  end

  // read mux, sampled in the rden cycle
  always_comb begin
    rd_mux = '0;
    unique case (ofs)
      3'd0:    rd_mux = ID_VALUE;
      3'd1:    rd_mux = {27'd0, ctrl};
      3'd2:    rd_mux = status;
      3'd3:    rd_mux = {30'd0, irq_stat};
      3'd4:    rd_mux = cnt_q;
      3'd5:    rd_mux = cmp_q;
      3'd6:    rd_mux = scratch;
      default: rd_mux = empty ? '0 : mem[rptr];
    endcase
  end

  // registered read data and level interrupt
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      user_rd_data <= '0;
      user_irq     <= 1'b0;
    end else begin
      if (user_rden) user_rd_data <= rd_mux;
      user_irq <= (irq_stat[0] & ctrl[1])
                | (irq_stat[1] & ctrl[2])
                | (!empty & ctrl[3]);
    end
  end

endmodule

// File: tb/tb_xillybus_lite_regs.sv
// Directed bench for xillybus_lite_regs with a read-data scoreboard.
// Covers the XLITE_REGS_TIMER_EN build and the default build.
module tb_xillybus_lite_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd_data;
  logic        irq;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] A_ID   = 32'h00;
  localparam logic [31:0] A_CTRL = 32'h04;
  localparam logic [31:0] A_STAT = 32'h08;
  localparam logic [31:0] A_IRQ  = 32'h0C;
  localparam logic [31:0] A_CNT  = 32'h10;
  localparam logic [31:0] A_CMP  = 32'h14;
  localparam logic [31:0] A_SCR  = 32'h18;
  localparam logic [31:0] A_FIFO = 32'h1C;

  xillybus_lite_regs dut (
    .bus_clk      (clk),
    .bus_rst_n    (rst_n),
    .user_wren    (wren),
    .user_wstrb   (wstrb),
    .user_rden    (rden),
    .user_addr    (addr),
    .user_wr_data (wdata),
    .user_rd_data (rd_data),
    .user_irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic re,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e,
                      input string tag);
    wren = we; rden = re; addr = a; wdata = d; wstrb = s;
    if (re) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; wstrb = '0;
    if (re) begin
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
      else check(tag_q.pop_front(), rd_data, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    xfer(1'b1, 1'b0, a, d, s, 32'd0, "");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string tag);
    xfer(1'b0, 1'b1, a, 32'd0, 4'h0, e, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    rd(A_ID, 32'h584C_0001, "id");
    @(negedge clk);
    check("rd_hold", rd_data, 32'h584C_0001);
    rd(A_STAT, 32'h0000_0001, "status_reset");
    rd(32'hFFFF_FFE8, 32'h0000_0001, "status_alias");
    wr(A_ID, 32'h1234_5678, 4'hF);
    rd(A_ID, 32'h584C_0001, "id_ro");
    wr(A_SCR, 32'hAABB_CCDD, 4'b0101);
    rd(A_SCR, 32'h00BB_00DD, "scratch_strb");
    rd(32'h0000_001B, 32'h00BB_00DD, "scratch_lowbits");
    xfer(1'b1, 1'b1, A_SCR, 32'hCAFE_F00D, 4'hF, 32'h00BB_00DD, "rw_pre");
    rd(A_SCR, 32'hCAFE_F00D, "rw_post");
    wr(A_CTRL, 32'hFFFF_FFFF, 4'hF);
    rd(A_CTRL, 32'h0000_001F, "ctrl_mask");

`ifdef XLITE_REGS_TIMER_EN
    do_reset();
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CTRL, 32'h13, 4'hF);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("irq_rise_%0d", k), {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
    end
    rd(A_CNT, 32'd1, "cnt_reload");
    rd(A_IRQ, 32'd1, "timer_hit");
    wr(A_CTRL, 32'h12, 4'hF);
    wr(A_IRQ, 32'd1, 4'h1);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_drop", {31'd0, irq}, 32'd0);
    rd(A_IRQ, 32'd0, "hit_cleared");
    wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
    wr(A_CTRL, 32'h01, 4'hF);
    rd(A_CNT, 32'hFFFF_FFFF, "cnt_max");
    rd(A_CNT, 32'd0, "cnt_wrap");
    wr(A_CNT, 32'h100, 4'hF);
    rd(A_CNT, 32'h100, "cnt_override");
    wr(A_CMP, 32'h1122_3344, 4'b1000);
    rd(A_CMP, 32'h1100_0005, "cmp_strb");
`else
    do_reset();
    wr(A_CNT, 32'd7, 4'hF);
    wr(A_CTRL, 32'h01, 4'hF);
    rd(A_CNT, 32'd0, "cnt_absent");
    wr(A_CMP, 32'd9, 4'hF);
    rd(A_CMP, 32'd0, "cmp_absent");
    rd(A_CTRL, 32'h01, "ctrl_en");
    wr(A_CTRL, 32'h13, 4'hF);
    rd(A_CTRL, 32'h13, "ctrl_bits");
    repeat (100) @(negedge clk);
    rd(A_IRQ, 32'd0, "hit_stuck0");
`endif

    do_reset();
    wr(A_CTRL, 32'h08, 4'hF);
    wr(A_FIFO, 32'd55, 4'h0);
    rd(A_STAT, 32'h0000_0001, "push_nostrb");
    for (int i = 1; i <= 17; i++) wr(A_FIFO, i, 4'hF);
    check("irq_nonempty", {31'd0, irq}, 32'd1);
    rd(A_STAT, 32'h0000_1002, "status_full");
    rd(A_IRQ, 32'd2, "ovf_set");
    wr(A_IRQ, 32'd2, 4'h1);
    rd(A_IRQ, 32'd0, "ovf_clear");
    xfer(1'b1, 1'b1, A_FIFO, 32'd100, 4'hF, 32'd1, "pushpop_full");
    rd(A_STAT, 32'h0000_1002, "status_pushpop");
    rd(A_IRQ, 32'd0, "no_new_ovf");
    for (int i = 2; i <= 16; i++) rd(A_FIFO, i, $sformatf("pop_%0d", i));
    rd(A_FIFO, 32'd100, "pop_last");
    rd(A_FIFO, 32'd0, "pop_empty");
    rd(A_STAT, 32'h0000_0001, "status_empty");
    check("irq_empty", {31'd0, irq}, 32'd0);

    wr(A_SCR, 32'h1234_5678, 4'hF);
    rden = 1'b1; addr = A_ID;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rden = 1'b0;
    check("abort_rd", rd_data, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_hold", rd_data, 32'd0);
    rd(A_SCR, 32'd0, "abort_scratch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
